// File: rtl/acc_alu_pkg.sv
// Shared definitions for the accumulator-side execute stage: op codes,
// FSM state encoding and the default datapath width.
package acc_alu_pkg;

  localparam int ACC_WIDTH = 16;

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_AND    = 4'd2;
  localparam logic [3:0] OP_OR     = 4'd3;
  localparam logic [3:0] OP_NOT    = 4'd4;
  localparam logic [3:0] OP_SHL    = 4'd5;
  localparam logic [3:0] OP_SHR    = 4'd6;
  localparam logic [3:0] OP_MPY    = 4'd7;
  localparam logic [3:0] OP_CLR    = 4'd8;
  localparam logic [3:0] OP_LOAD   = 4'd9;
  localparam logic [3:0] OP_LOADMR = 4'd10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/booth_mul_core.sv
// Radix-2 Booth multiplier datapath: A/Q/q-1 registers and step counter.
// a_out/q_out present the post-step values so the owner can capture the product on the final step edge.
module booth_mul_core
  import acc_alu_pkg::*;
#(
  parameter int WIDTH     = ACC_WIDTH,
  parameter int MUL_STEPS = ACC_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic signed [WIDTH-1:0] m,
  input  logic        [WIDTH-1:0] q_in,
  input  logic                    step_en,
  output logic        [WIDTH-1:0] a_out,
  output logic        [WIDTH-1:0] q_out,
  output logic                    last_step
);

  localparam int CNT_W = $clog2(MUL_STEPS);

  logic signed [WIDTH:0]   a_q;
  logic signed [WIDTH:0]   m_q;
  logic        [WIDTH-1:0] q_q;
  logic                    qm1_q;
  logic        [CNT_W-1:0] cnt_q;

  logic signed [WIDTH:0]   sum;
  logic signed [WIDTH:0]   a_nxt;
  logic        [WIDTH-1:0] q_nxt;

  // A is one bit wider than M so that A-M cannot wrap when M is the most negative value
  always_comb begin
    sum = a_q;
    unique case ({q_q[0], qm1_q})
      2'b01:   sum = a_q + m_q;
      2'b10:   sum = a_q - m_q;
      default: sum = a_q;
    endcase
    a_nxt = sum >>> 1;
    q_nxt = {sum[0], q_q[WIDTH-1:1]};
  end

  assign a_out     = a_nxt[WIDTH-1:0];
  assign q_out     = q_nxt;
  assign last_step = step_en && (cnt_q == CNT_W'(MUL_STEPS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
    end else if (step_en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      a_q   <= '0;
      m_q   <= {m[WIDTH-1], m};
      q_q   <= q_in;
      qm1_q <= 1'b0;
    end else if (step_en) begin
      a_q   <= a_nxt;
      q_q   <= q_nxt;
      qm1_q <= q_q[0];
    end
  end

endmodule

// File: rtl/acc_alu.sv
// Accumulator execute stage: single-cycle ALU ops on ACC plus an iterative
// signed multiply whose 32-bit product lands in {MR, ACC}.
module acc_alu
  import acc_alu_pkg::*;
#(
  parameter int WIDTH     = ACC_WIDTH,
  parameter int MUL_STEPS = ACC_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic        [3:0]       op,
  input  logic signed [WIDTH-1:0] br_data,
  output logic        [WIDTH-1:0] acc_out,
  output logic        [WIDTH-1:0] mr_out,
  output logic                    busy,
  output logic                    done,
  output logic                    zf,
  output logic                    nf,
  output logic                    of
);

  state_t                  state_q;
  logic signed [WIDTH-1:0] acc_q;
  logic        [WIDTH-1:0] mr_q;
  logic                    done_q;
  logic                    zf_q;
  logic                    nf_q;
  logic                    of_q;

  logic signed [WIDTH-1:0] res;
  logic                    res_of;
  logic                    res_upd;

  logic                    mul_load;
  logic                    mul_step;
  logic        [WIDTH-1:0] prod_hi;
  logic        [WIDTH-1:0] prod_lo;
  logic                    mul_last;

  function automatic logic add_ovf(input logic signed [WIDTH-1:0] a,
                                   input logic signed [WIDTH-1:0] b,
                                   input logic signed [WIDTH-1:0] s);
    return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
  endfunction

  function automatic logic sub_ovf(input logic signed [WIDTH-1:0] a,
                                   input logic signed [WIDTH-1:0] b,
                                   input logic signed [WIDTH-1:0] d);
    return (a[WIDTH-1] != b[WIDTH-1]) && (d[WIDTH-1] != a[WIDTH-1]);
  endfunction

  always_comb begin
    res     = acc_q;
    res_of  = 1'b0;
    res_upd = 1'b1;
    unique case (op)
      OP_ADD: begin
        res    = acc_q + br_data;
        res_of = add_ovf(acc_q, br_data, res);
      end
      OP_SUB: begin
        res    = acc_q - br_data;
        res_of = sub_ovf(acc_q, br_data, res);
      end
      OP_AND:    res = acc_q & br_data;
      OP_OR:     res = acc_q | br_data;
      OP_NOT:    res = ~acc_q;
      OP_SHL: begin
        res    = acc_q <<< 1;
        res_of = acc_q[WIDTH-1] ^ acc_q[WIDTH-2];
      end
      OP_SHR:    res = acc_q >>> 1;
      OP_CLR:    res = '0;
      OP_LOAD:   res = br_data;
      OP_LOADMR: res = mr_q;
      default:   res_upd = 1'b0;
    endcase
  end

  assign busy     = (state_q == MUL);
  assign mul_load = start && !busy && (op == OP_MPY);
  assign mul_step = busy;

  booth_mul_core #(
    .WIDTH     (WIDTH),
    .MUL_STEPS (MUL_STEPS)
  ) u_booth (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (mul_load),
    .m         (br_data),
    .q_in      (acc_q),
    .step_en   (mul_step),
    .a_out     (prod_hi),
    .q_out     (prod_lo),
    .last_step (mul_last)
  );

  // DONE behaves exactly like IDLE for accepting new work; it only marks the done cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mr_q    <= '0;
      done_q  <= 1'b0;
      zf_q    <= 1'b0;
      nf_q    <= 1'b0;
      of_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        MUL: begin
          if (mul_last) begin
            mr_q    <= prod_hi;
            acc_q   <= prod_lo;
            zf_q    <= ({prod_hi, prod_lo} == '0);
            nf_q    <= prod_hi[WIDTH-1];
            of_q    <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          state_q <= IDLE;
          if (start) begin
            if (op == OP_MPY) begin
              state_q <= MUL;
            end else begin
              done_q <= 1'b1;
              if (res_upd) begin
                acc_q <= res;
                zf_q  <= (res == '0);
                nf_q  <= res[WIDTH-1];
                of_q  <= res_of;
              end
            end
          end
        end
      endcase
    end
  end

  assign acc_out = acc_q;
  assign mr_out  = mr_q;
  assign done    = done_q;
  assign zf      = zf_q;
  assign nf      = nf_q;
  assign of      = of_q;

endmodule

// File: tb/tb_acc_alu.sv
// Directed bench for acc_alu: single-cycle ops, Booth multiply, dropped starts and reset abort.
module tb_acc_alu;
  import acc_alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  op;
  logic [15:0] br_data;
  logic [15:0] acc_out;
  logic [15:0] mr_out;
  logic        busy;
  logic        done;
  logic        zf;
  logic        nf;
  logic        of;

  int errors = 0;
  int checks = 0;

  acc_alu dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .br_data (br_data),
    .acc_out (acc_out),
    .mr_out  (mr_out),
    .busy    (busy),
    .done    (done),
    .zf      (zf),
    .nf      (nf),
    .of      (of)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [3:0] o, input logic [15:0] d);
    @(negedge clk);
    start   = 1'b1;
    op      = o;
    br_data = d;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // flags compared as {zf, nf, of}
  task automatic op_chk(input string tag, input logic [3:0] o, input logic [15:0] d,
                        input logic [15:0] exp_acc, input logic [2:0] exp_flags);
    issue(o, d);
    check({tag, "_acc"}, acc_out, exp_acc);
    check({tag, "_flags"}, {zf, nf, of}, exp_flags);
    check({tag, "_done"}, done, 1'b1);
  endtask

  task automatic wait_mul(output int n);
    n = 0;
    while (busy && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    int n;
    int dn;
    rst_n   = 1'b0;
    start   = 1'b0;
    op      = 4'd0;
    br_data = 16'd0;
    #12;
    check("rst_acc", acc_out, 16'h0);
    check("rst_mr", mr_out, 16'h0);
    check("rst_ctl", {busy, done}, 2'b00);
    check("rst_flags", {zf, nf, of}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD overflow
    op_chk("load7fff", OP_LOAD, 16'h7FFF, 16'h7FFF, 3'b000);
    op_chk("add_ovf", OP_ADD, 16'h0001, 16'h8000, 3'b011);
    @(posedge clk);
    #1;
    check("add_done_low", done, 1'b0);

    // SUB to zero
    op_chk("load5", OP_LOAD, 16'h0005, 16'h0005, 3'b000);
    op_chk("sub_zero", OP_SUB, 16'h0005, 16'h0000, 3'b100);

    // MPY -3 * 7
    op_chk("load_m3", OP_LOAD, 16'hFFFD, 16'hFFFD, 3'b010);
    issue(OP_MPY, 16'h0007);
    check("mpy_busy", busy, 1'b1);
    check("mpy_nodone", done, 1'b0);
    wait_mul(n);
    check("mpy_busy_cycles", n, 16);
    check("mpy_done", done, 1'b1);
    check("mpy_prod", {mr_out, acc_out}, 32'hFFFFFFEB);
    check("mpy_flags", {zf, nf, of}, 3'b010);
    @(posedge clk);
    #1;
    check("mpy_done_pulse", {busy, done}, 2'b00);

    // MPY most-negative corner
    op_chk("load8000", OP_LOAD, 16'h8000, 16'h8000, 3'b010);
    issue(OP_MPY, 16'h8000);
    wait_mul(n);
    check("corner_cycles", n, 16);
    check("corner_prod", {mr_out, acc_out}, 32'h40000000);
    check("corner_flags", {zf, nf, of}, 3'b000);

    // remaining single-cycle ops, chained from MR = 0x4000
    op_chk("loadmr", OP_LOADMR, 16'h1234, 16'h4000, 3'b000);
    op_chk("shl_ovf", OP_SHL, 16'h0000, 16'h8000, 3'b011);
    op_chk("shr", OP_SHR, 16'h0000, 16'hC000, 3'b010);
    op_chk("not", OP_NOT, 16'h0000, 16'h3FFF, 3'b000);
    op_chk("and", OP_AND, 16'h0F0F, 16'h0F0F, 3'b000);
    op_chk("or", OP_OR, 16'hF000, 16'hFF0F, 3'b010);
    op_chk("clr", OP_CLR, 16'hFFFF, 16'h0000, 3'b100);
    op_chk("undef", 4'd11, 16'h1234, 16'h0000, 3'b100);
    check("mr_hold", mr_out, 16'h4000);

    // start while busy is dropped
    op_chk("load_m3b", OP_LOAD, 16'hFFFD, 16'hFFFD, 3'b010);
    issue(OP_MPY, 16'h0007);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    issue(OP_ADD, 16'h0001);
    check("drop_busy", busy, 1'b1);
    dn = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (done) dn++;
    end
    check("drop_done_count", dn, 1);
    check("drop_prod", {mr_out, acc_out}, 32'hFFFFFFEB);

    // reset in the middle of a multiply
    op_chk("load5b", OP_LOAD, 16'h0005, 16'h0005, 3'b000);
    issue(OP_MPY, 16'h0005);
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    check("abort_acc", acc_out, 16'h0);
    check("abort_mr", mr_out, 16'h0);
    check("abort_ctl", {busy, done}, 2'b00);
    check("abort_flags", {zf, nf, of}, 3'b000);
    dn = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) dn++;
    end
    check("abort_quiet", dn, 0);
    @(negedge clk);
    rst_n = 1'b1;
    op_chk("load3", OP_LOAD, 16'h0003, 16'h0003, 3'b000);
    check("load3_mr", mr_out, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
